// File: rtl/if_id_stage_ctrl_pkg.sv
// Shared definitions for the fetch / IF-ID stage controller: opcode
// constants, the canonical bubble word and the controller state encoding.
package if_id_stage_ctrl_pkg;

    typedef logic [15:0] word_t;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    // Bubble word: NOP opcode with all operand fields zero.
    localparam word_t NOP_INSTR_ENC = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } stage_state_e;

endpackage

// File: rtl/if_id_stage_ctrl_if.sv
// Bundle of fetch, hazard, redirect and decode-side signals around the
// IF/ID stage. master = the stage controller, slave = its surroundings.
interface if_id_stage_ctrl_if;
    import if_id_stage_ctrl_pkg::*;

    word_t fetch_instr;
    logic  fetch_ready;
    logic  haz_nop;
    logic  haz_pc_stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    word_t pc;
    word_t id_instr;
    word_t id_pc_inc;
    logic  id_valid;
    logic  stall_err;

    modport master (
        input  fetch_instr, fetch_ready, haz_nop, haz_pc_stall,
               redirect, redirect_pc, halt,
        output pc, id_instr, id_pc_inc, id_valid, stall_err
    );

    modport slave (
        output fetch_instr, fetch_ready, haz_nop, haz_pc_stall,
               redirect, redirect_pc, halt,
        input  pc, id_instr, id_pc_inc, id_valid, stall_err
    );

endinterface

// File: rtl/cla16b.sv
// 16-bit adder built from four 4-bit groups; carries between groups use
// group generate/propagate so the inter-group path is one level deep.
module cla16b (
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] g;
    logic [15:0] p;

    assign g = in_a & in_b;
    assign p = in_a ^ in_b;

    // Sum bits per group, then group carry-out from group generate/propagate.
    always_comb begin
        logic       blk_c;
        logic       c;
        logic [3:0] gs;
        logic [3:0] ps;
        blk_c = c_in;
        c     = 1'b0;
        gs    = '0;
        ps    = '0;
        sum   = '0;
        for (int b = 0; b < 4; b++) begin
            gs = g[b*4 +: 4];
            ps = p[b*4 +: 4];
            c  = blk_c;
            for (int i = 0; i < 4; i++) begin
                sum[b*4+i] = ps[i] ^ c;
                c = gs[i] | (ps[i] & c);
            end
            blk_c = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                  | (ps[3] & ps[2] & ps[1] & gs[0]) | ((&ps) & blk_c);
        end
        c_out = blk_c;
    end

endmodule

// File: rtl/dff.sv
// Single-bit storage cell with asynchronous active-low reset to RST_VAL.
module dff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Capture d on the rising edge; reset forces RST_VAL at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= RST_VAL;
        else      q <= d;
    end

endmodule

// File: rtl/dff_16.sv
// 16-bit storage cell with asynchronous active-low reset to RST_VAL.
module dff_16 #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Capture d on the rising edge; reset forces RST_VAL at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= RST_VAL;
        else      q <= d;
    end

endmodule

// File: rtl/if_id_stage_ctrl.sv
// Fetch-side stage controller: owns the PC and the IF/ID register and, each
// clock, advances, holds or bubbles in response to redirect, halt, hazard
// requests and instruction-memory readiness. Also runs a stall watchdog.
module if_id_stage_ctrl #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] NOP_INSTR    = if_id_stage_ctrl_pkg::NOP_INSTR_ENC,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          STALL_MAX    = 7
) (
    input  logic               clk,
    input  logic               rst,
    if_id_stage_ctrl_if.master bus
);
    import if_id_stage_ctrl_pkg::*;

    localparam int              WD_W       = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [WD_W-1:0] WD_MAX     = WD_W'(STALL_MAX);
    localparam logic [1:0]      FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [1:0]      RUN_ENC    = ST_RUN;

    logic [1:0]      state_q, state_d;
    stage_state_e    state;
    logic [15:0]     pc_q, pc_d, pc_inc;
    logic [15:0]     id_instr_q, id_instr_d;
    logic [15:0]     id_pc_inc_q, id_pc_inc_d;
    logic            id_valid_q, id_valid_d;
    logic            err_q, err_d;
    logic [1:0]      flush_q, flush_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            hold_cyc;
    logic            pc_inc_unused_co;

    assign state = stage_state_e'(state_q);

    cla16b u_pc_inc (
        .in_a  (pc_q),
        .in_b  (16'h0002),
        .c_in  (1'b0),
        .sum   (pc_inc),
        .c_out (pc_inc_unused_co)
    );

    // Next-state and next-register values; priority is redirect, halt,
    // hold (stall or memory wait), flush bubble, hazard bubble, normal.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_instr_d  = id_instr_q;
        id_pc_inc_d = id_pc_inc_q;
        id_valid_d  = id_valid_q;
        flush_d     = flush_q;
        hold_cyc    = 1'b0;

        if (state == ST_HALTED) begin
            // Frozen until reset; redirect is deliberately ignored here.
            id_valid_d = 1'b0;
        end else if (bus.redirect) begin
            pc_d       = bus.redirect_pc;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            flush_d    = FLUSH_INIT;
            state_d    = (FLUSH_INIT != 2'd0) ? ST_FLUSH : ST_RUN;
        end else if (bus.halt) begin
            state_d    = ST_HALTED;
            id_valid_d = 1'b0;
        end else if (bus.haz_pc_stall || !bus.fetch_ready) begin
            // The stalled instruction already sits in ID, so ID gets a
            // bubble instead of a repeat. A flush in progress stays paused.
            hold_cyc   = 1'b1;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            if (state != ST_FLUSH) state_d = ST_HOLD;
        end else if (state == ST_FLUSH) begin
            pc_d       = pc_inc;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            if (flush_q <= 2'd1) begin
                flush_d = 2'd0;
                state_d = ST_RUN;
            end else begin
                flush_d = flush_q - 2'd1;
            end
        end else if (bus.haz_nop) begin
            // Discard the wrong-path fetch but keep fetching ahead.
            pc_d       = pc_inc;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            state_d    = ST_RUN;
        end else begin
            pc_d        = pc_inc;
            id_instr_d  = bus.fetch_instr;
            id_pc_inc_d = pc_inc;
            id_valid_d  = 1'b1;
            state_d     = ST_RUN;
        end
    end

    // Watchdog: saturating count of consecutive hold cycles, sticky error.
    always_comb begin
        wd_d  = '0;
        if (hold_cyc) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        err_d = err_q | (hold_cyc && (wd_d == WD_MAX));
    end

    dff_16 #(.RST_VAL(RESET_PC))  u_pc        (.clk(clk), .rst(rst), .d(pc_d),        .q(pc_q));
    dff_16 #(.RST_VAL(NOP_INSTR)) u_id_instr  (.clk(clk), .rst(rst), .d(id_instr_d),  .q(id_instr_q));
    dff_16 #(.RST_VAL(16'h0000))  u_id_pc_inc (.clk(clk), .rst(rst), .d(id_pc_inc_d), .q(id_pc_inc_q));
    dff    #(.RST_VAL(1'b0))      u_id_valid  (.clk(clk), .rst(rst), .d(id_valid_d),  .q(id_valid_q));
    dff    #(.RST_VAL(1'b0))      u_err       (.clk(clk), .rst(rst), .d(err_d),       .q(err_q));

    for (genvar i = 0; i < 2; i++) begin : g_state
        dff #(.RST_VAL(RUN_ENC[i])) u_ff (.clk(clk), .rst(rst), .d(state_d[i]), .q(state_q[i]));
    end

    for (genvar i = 0; i < 2; i++) begin : g_flush
        dff #(.RST_VAL(1'b0)) u_ff (.clk(clk), .rst(rst), .d(flush_d[i]), .q(flush_q[i]));
    end

    for (genvar i = 0; i < WD_W; i++) begin : g_wd
        dff #(.RST_VAL(1'b0)) u_ff (.clk(clk), .rst(rst), .d(wd_d[i]), .q(wd_q[i]));
    end

    assign bus.pc        = pc_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc_inc = id_pc_inc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.stall_err = err_q;

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Directed bench for if_id_stage_ctrl (FLUSH_CYCLES=2, STALL_MAX=7).
// Each step drives inputs, queues the expected post-edge outputs, then pops
// and checks them one time unit after the rising edge.
module tb_if_id_stage_ctrl;
    import if_id_stage_ctrl_pkg::*;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        string       tag;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        vld;
        logic [15:0] inc;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] cur_pc = 16'h0000;
    exp_t sb[$];

    if_id_stage_ctrl_if bus ();

    if_id_stage_ctrl #(
        .RESET_PC     (16'h0000),
        .NOP_INSTR    (16'h0800),
        .FLUSH_CYCLES (2),
        .STALL_MAX    (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory image: distinct, never equal to the bubble word.
    function automatic logic [15:0] imem(input logic [15:0] a);
        return {4'hC, a[11:0]};
    endfunction

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, obs, want);
        end
    endtask

    task automatic step(input string tag, input logic rdy, input logic stl, input logic nop,
                        input logic rdr, input logic [15:0] rpc, input logic hlt,
                        input logic [15:0] e_pc, input logic [15:0] e_instr, input logic e_vld,
                        input logic [15:0] e_inc, input logic e_err);
        exp_t e;
        bus.fetch_ready  = rdy;
        bus.haz_pc_stall = stl;
        bus.haz_nop      = nop;
        bus.redirect     = rdr;
        bus.redirect_pc  = rpc;
        bus.halt         = hlt;
        bus.fetch_instr  = imem(cur_pc);
        e.tag = tag; e.pc = e_pc; e.instr = e_instr; e.vld = e_vld; e.inc = e_inc; e.err = e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "pc", bus.pc, e.pc);
        chk(e.tag, "id_instr", bus.id_instr, e.instr);
        chk(e.tag, "id_valid", {15'b0, bus.id_valid}, {15'b0, e.vld});
        if (e.vld) chk(e.tag, "id_pc_inc", bus.id_pc_inc, e.inc);
        chk(e.tag, "stall_err", {15'b0, bus.stall_err}, {15'b0, e.err});
        cur_pc = e.pc;
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, "pc", bus.pc, 16'h0000);
        chk(tag, "id_instr", bus.id_instr, NOP);
        chk(tag, "id_pc_inc", bus.id_pc_inc, 16'h0000);
        chk(tag, "id_valid", {15'b0, bus.id_valid}, 16'h0000);
        chk(tag, "stall_err", {15'b0, bus.stall_err}, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed no end expected end");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus.fetch_ready = 1'b0; bus.haz_pc_stall = 1'b0; bus.haz_nop = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 16'h0000; bus.halt = 1'b0;
        bus.fetch_instr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;
        cur_pc = 16'h0000;

        // Straight-line fetch
        step("run0", 1,0,0,0,16'h0,0, 16'h0002, 16'hC000, 1, 16'h0002, 0);
        step("run1", 1,0,0,0,16'h0,0, 16'h0004, 16'hC002, 1, 16'h0004, 0);
        step("run2", 1,0,0,0,16'h0,0, 16'h0006, 16'hC004, 1, 16'h0006, 0);
        // Hazard stall for three cycles, then release
        for (int i = 0; i < 3; i++)
            step("stall", 1,1,0,0,16'h0,0, 16'h0006, NOP, 0, 16'h0, 0);
        step("stall_rel", 1,0,0,0,16'h0,0, 16'h0008, 16'hC006, 1, 16'h0008, 0);
        // Bubble request alone
        step("haz_nop", 1,0,1,0,16'h0,0, 16'h000A, NOP, 0, 16'h0, 0);
        step("after_nop", 1,0,0,0,16'h0,0, 16'h000C, 16'hC00A, 1, 16'h000C, 0);
        // Redirect together with stall: redirect wins, two bubbles total
        step("rdr_stall", 1,1,0,1,16'h0040,0, 16'h0040, NOP, 0, 16'h0, 0);
        step("flush_a", 1,0,0,0,16'h0,0, 16'h0042, NOP, 0, 16'h0, 0);
        step("flush_a_end", 1,0,0,0,16'h0,0, 16'h0044, 16'hC042, 1, 16'h0044, 0);
        // Flush paused by memory wait
        step("rdr_80", 1,0,0,1,16'h0080,0, 16'h0080, NOP, 0, 16'h0, 0);
        step("flush_wait", 0,0,0,0,16'h0,0, 16'h0080, NOP, 0, 16'h0, 0);
        step("flush_b", 1,0,0,0,16'h0,0, 16'h0082, NOP, 0, 16'h0, 0);
        step("flush_b_end", 1,0,0,0,16'h0,0, 16'h0084, 16'hC082, 1, 16'h0084, 0);
        // Redirect out of HOLD
        step("hold", 1,1,0,0,16'h0,0, 16'h0084, NOP, 0, 16'h0, 0);
        step("rdr_hold", 1,0,0,1,16'h0100,0, 16'h0100, NOP, 0, 16'h0, 0);
        step("flush_c", 1,0,0,0,16'h0,0, 16'h0102, NOP, 0, 16'h0, 0);
        step("flush_c_end", 1,0,0,0,16'h0,0, 16'h0104, 16'hC102, 1, 16'h0104, 0);
        // Watchdog: eight memory-wait cycles, error from the seventh on
        for (int i = 1; i <= 8; i++)
            step("wdog", 0,0,0,0,16'h0,0, 16'h0104, NOP, 0, 16'h0, (i >= 7));
        step("wdog_rel", 1,0,0,0,16'h0,0, 16'h0106, 16'hC104, 1, 16'h0106, 1);
        // PC wrap at the top of the address space
        step("rdr_wrap", 1,0,0,1,16'hFFFC,0, 16'hFFFC, NOP, 0, 16'h0, 1);
        step("flush_wrap", 1,0,0,0,16'h0,0, 16'hFFFE, NOP, 0, 16'h0, 1);
        step("wrap", 1,0,0,0,16'h0,0, 16'h0000, 16'hCFFE, 1, 16'h0000, 1);
        step("post_wrap", 1,0,0,0,16'h0,0, 16'h0002, 16'hC000, 1, 16'h0002, 1);
        // HALT freezes everything; redirect and memory toggling ignored
        step("halt", 1,0,0,0,16'h0,1, 16'h0002, 16'hC000, 0, 16'h0, 1);
        step("halt_rdr", 1,0,0,1,16'h0200,0, 16'h0002, 16'hC000, 0, 16'h0, 1);
        step("halt_nrdy", 0,0,0,0,16'h0,0, 16'h0002, 16'hC000, 0, 16'h0, 1);
        step("halt_rdy", 1,0,0,0,16'h0,0, 16'h0002, 16'hC000, 0, 16'h0, 1);
        // Only reset leaves HALTED; applied between clock edges
        #2 rst = 1'b0;
        #1 chk_reset("rst_halt");
        @(negedge clk);
        rst = 1'b1;
        cur_pc = 16'h0000;
        step("rst_run", 1,0,0,0,16'h0,0, 16'h0002, 16'hC000, 1, 16'h0002, 0);
        // Asynchronous reset in the middle of a flush
        step("rdr_mid", 1,0,0,1,16'h0040,0, 16'h0040, NOP, 0, 16'h0, 0);
        #2 rst = 1'b0;
        #1 chk_reset("rst_flush");
        @(negedge clk);
        rst = 1'b1;
        cur_pc = 16'h0000;
        step("rst_flush_run", 1,0,0,0,16'h0,0, 16'h0002, 16'hC000, 1, 16'h0002, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
